nn_infer_ctrl: RTL

Upstream control stage for the hls4ml inference core wrapper. Accepts a stream of 16-bit fixed-point features over valid/ready, packs each group of N_FEAT words into the core's flat input vector, and issues the start and input-valid strobes. It then waits for the core's result and completion and presents the result downstream over valid/ready. It also flags framing errors and hung-core timeouts.

---
 rtl/nn_ctrl_pkg.sv | 12 +
 rtl/nn_wd_timer.sv | 18 +
 rtl/nn_infer_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared state encoding and default sizing for the inference control stage
package nn_ctrl_pkg;
  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, HOLD} state_t;
  localparam int FEAT_W_DEF = 16;
  localparam int N_FEAT_DEF = 3;
  localparam int OUT_W_DEF = 16;
  localparam int TIMEOUT_DEF = 1023;
  function automatic int tmr_width(input int t);
    return $clog2(t + 1);
  endfunction
  localparam int TMR_W = tmr_width(TIMEOUT_DEF);
endpackage

// File: rtl/nn_wd_timer.sv
// nn_wd_timer: clearable watchdog counter, expired on the LIMIT-th enabled cycle
module nn_wd_timer #(
  parameter int LIMIT = 1023,
  parameter int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/nn_infer_ctrl.sv
// nn_infer_ctrl: packs feature words for the inference core, launches it and returns its result
module nn_infer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int FEAT_W = FEAT_W_DEF,
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FEAT_W-1:0]        s_feat_data,
  input  logic                     s_feat_valid,
  input  logic                     s_feat_last,
  output logic                     s_feat_ready,
  output logic                     core_start,
  output logic [FEAT_W*N_FEAT-1:0] core_input,
  output logic                     core_input_vld,
  input  logic [OUT_W-1:0]         core_out,
  input  logic                     core_out_vld,
  input  logic                     core_done,
  output logic [OUT_W-1:0]         m_res_data,
  output logic                     m_res_valid,
  input  logic                     m_res_ready,
  input  logic                     clr_err,
  output logic                     err_framing,
  output logic                     err_timeout,
  output logic                     busy
);
  localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_FEAT - 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FEAT_W*N_FEAT-1:0] vec_q, vec_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic seen_out_q, seen_out_d, seen_done_q, seen_done_d;
  logic ready_q, start_q, valid_q, busy_q, frm_q, to_q;
  logic accept, set_frm, set_to, tmr_en, tmr_clr, tmr_exp;
  nn_wd_timer #(.LIMIT(TIMEOUT), .W(tmr_width(TIMEOUT))) u_wd (
    .clk(clk), .rst_n(rst_n), .en_i(tmr_en), .clr_i(tmr_clr), .expired_o(tmr_exp)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    vec_d = vec_q;
    res_d = res_q;
    seen_out_d = seen_out_q;
    seen_done_d = seen_done_q;
    accept = s_feat_valid & ready_q;
    set_frm = 1'b0;
    set_to = 1'b0;
    tmr_en = 1'b0;
    tmr_clr = 1'b0;
    case (state_q)
      COLLECT: if (accept) begin
        vec_d[idx_q*FEAT_W +: FEAT_W] = s_feat_data;
        idx_d = (idx_q == LAST_IDX || s_feat_last) ? '0 : idx_q + 1'b1;
        set_frm = (idx_q == LAST_IDX) ? ~s_feat_last : s_feat_last;
        state_d = (idx_q == LAST_IDX) ? LAUNCH : COLLECT;
      end
      LAUNCH: begin
        tmr_clr = 1'b1;
        seen_out_d = 1'b0;
        seen_done_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        res_d = core_out_vld ? core_out : res_q;
        seen_out_d = seen_out_q | core_out_vld;
        seen_done_d = seen_done_q | core_done;
        set_to = ~(seen_out_d & seen_done_d) & tmr_exp;
        state_d = (seen_out_d & seen_done_d) ? HOLD : tmr_exp ? COLLECT : WAIT;
      end
      HOLD: state_d = m_res_ready ? COLLECT : HOLD;
      default: state_d = COLLECT;
    endcase
  end
  // Strobes are registered from next state so every output is a flop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q <= '0;
      vec_q <= '0;
      res_q <= '0;
      seen_out_q <= 1'b0;
      seen_done_q <= 1'b0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      frm_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vec_q <= vec_d;
      res_q <= res_d;
      seen_out_q <= seen_out_d;
      seen_done_q <= seen_done_d;
      ready_q <= state_d == COLLECT;
      start_q <= state_d == LAUNCH;
      valid_q <= state_d == HOLD;
      busy_q <= state_d != COLLECT;
      frm_q <= set_frm | (frm_q & ~clr_err);
      to_q <= set_to | (to_q & ~clr_err);
    end
  assign s_feat_ready = ready_q;
  assign core_start = start_q;
  assign core_input_vld = start_q;
  assign core_input = vec_q;
  assign m_res_data = res_q;
  assign m_res_valid = valid_q;
  assign err_framing = frm_q;
  assign err_timeout = to_q;
  assign busy = busy_q;
endmodule
